hum_ctrl: RTL and testbench
===========================

# hum_ctrl

Humidity regulation controller. It sits directly upstream of the humidity LED blinker and drives the `humidifier_en` / `dehumidifier_en` pair that the blinker consumes. It accepts validated humidity samples from the sensor interface and applies threshold hysteresis, multi-sample persistence, a minimum on-time and an inter-mode cooldown. At most one enable is ever asserted.

## Interface
- `DATA_W`, 8: width of humidity sample and thresholds, in percent RH.
- `PERSIST`, 3: number of consecutive qualifying samples needed to start a mode (1..15).
- `MIN_ON_CYCLES`, 100_000_000: minimum cycles spent in HUMIDIFY or DEHUMIDIFY (1 s at 100 MHz).
- `COOLDOWN_CYCLES`, 200_000_000: cycles with both enables low after a mode ends.

- `pclk`  in  1  clock.
- `preset`  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- `ctrl_en`  in  1  controller enable; low forces idle.
- `hum_valid`  in  1  one-cycle sample strobe; no backpressure.
- `hum_data`  in  DATA_W  humidity sample, legal range 0..100.
- `hum_low_th`  in  DATA_W  dry threshold.
- `hum_high_th`  in  DATA_W  wet threshold.
- `hyst`  in  DATA_W  release hysteresis.
- `humidifier_en`  out  1  registered; high in HUMIDIFY.
- `dehumidifier_en`  out  1  registered; high in DEHUMIDIFY.
- `hum_fault`  out  1  sticky out-of-range sample flag.
- `state_o`  out  2  current state encoding.

## Operation
- States: IDLE=0, HUMIDIFY=1, DEHUMIDIFY=2, COOLDOWN=3. Enables decode from the state only, so they are mutually exclusive by construction.
- A sample is accepted when `hum_valid`=1 on a `pclk` edge.
- Sample classification:
  - dry: `hum_data < hum_low_th`
  - wet: `hum_data > hum_high_th`
- Persistence counters `dry_cnt` / `wet_cnt` saturate at PERSIST:
  - A matching accepted sample increments its counter.
  - A non-matching accepted sample clears it.
  - Both counters are cleared on entry to any non-IDLE state and are held at 0 outside IDLE.
- IDLE:
  - The sample that brings `dry_cnt` to PERSIST moves the FSM to HUMIDIFY.
  - Likewise, `wet_cnt` reaching PERSIST moves it to DEHUMIDIFY.
  - If the configuration is invalid (`hum_low_th >= hum_high_th`), the FSM stays in IDLE and the counters are held at 0.
- HUMIDIFY:
  - The dwell timer starts at 0 on entry and saturates; `dwell_done` asserts once `MIN_ON_CYCLES` cycles have elapsed in the state.
  - Exit to COOLDOWN on an accepted sample with `dwell_done`=1 and `hum_data >= min(hum_low_th + hyst, 100)`.
  - The sum is computed at DATA_W+1 bits.
- DEHUMIDIFY:
  - Exit to COOLDOWN on an accepted sample with `dwell_done`=1 and `hum_data <= max(hum_high_th - hyst, 0)`.
  - The difference is computed at DATA_W+1 bits, signed.
- COOLDOWN: both enables low for exactly `COOLDOWN_CYCLES` cycles, then IDLE. Samples are ignored.
- Fault:
  - An accepted sample with `hum_data > 100` sets `hum_fault` and forces IDLE from any state, with no cooldown.
  - While `hum_fault`=1, all samples are ignored.
- `ctrl_en`=0:
  - Next cycle: IDLE, counters and timer cleared, `hum_fault` cleared.
  - This takes priority over every other event in the same cycle, including a fault sample.
- Priority: `preset` > `ctrl_en`=0 > fault sample > normal transitions.

## Timing
- Reset values: state IDLE, `humidifier_en`=0, `dehumidifier_en`=0, `hum_fault`=0, `state_o`=0, counters and timer 0.
- Enable latency: the enable rises on the edge after the PERSIST-th qualifying sample edge (1 cycle).
- A mode holds its enable for at least `MIN_ON_CYCLES` cycles.
- COOLDOWN lasts exactly `COOLDOWN_CYCLES` cycles.
- A fault sample or `ctrl_en` low drops the enables 1 cycle later.
- Reset asserted mid-mode clears everything on the same edge.
- Timer width: `$clog2(max(MIN_ON_CYCLES, COOLDOWN_CYCLES)+1)` bits, shared between dwell and cooldown and cleared on every state change.

## Structure
- `hum_ctrl_pkg` contains:
  - `hum_state_e` (2-bit enum)
  - `HUM_MAX` = 100
  - state-to-enable decode function
- Sub-module `hum_persist`: saturating consecutive-sample counter with inc/clear/hold and a `hit` output. It is instantiated twice, once for dry and once for wet.
- The timer is inline. The existing `counter_en` is not reused, because its reset style differs.

## Test plan
Bench parameters: PERSIST=3, MIN_ON=8, COOLDOWN=4; thresholds low=40, high=60, hyst=5.
- Reset check: `preset` pulse -> all outputs 0, `state_o`=0.
- Dry persistence, positive: samples 35, 35, 35 -> `humidifier_en`=1 one cycle after the third sample.
- Dry persistence, negative: samples 35, 35, 50, 35 -> `humidifier_en` stays 0.
- HUMIDIFY release:
  - Sample 46 at cycle 3 of HUMIDIFY -> stays on.
  - Sample 44 after dwell -> stays on.
  - Sample 46 after dwell -> off, exactly 4 cycles of COOLDOWN, then IDLE.
- DEHUMIDIFY release:
  - Samples 70 ×3 -> `dehumidifier_en`=1.
  - After dwell, 56 -> stays on.
  - After dwell, 55 -> COOLDOWN.
- Fault handling:
  - Sample 101 during HUMIDIFY -> next cycle enables 0, `hum_fault`=1, IDLE.
  - Samples 35 ×3 afterwards -> ignored.
  - One cycle of `ctrl_en`=0 -> `hum_fault`=0.
- Saturation and invalid configuration:
  - With low=98, hyst=10: only sample 100 releases HUMIDIFY.
  - With high=5, hyst=10: only sample 0 releases DEHUMIDIFY.
  - With low=60, high=40: stays IDLE for any samples.

Source files
------------

// File: rtl/hum_ctrl_pkg.sv
// rtl/hum_ctrl_pkg.sv - shared types, constants and enable decode for the humidity controller
package hum_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_HUMIDIFY   = 2'd1,
        ST_DEHUMIDIFY = 2'd2,
        ST_COOLDOWN   = 2'd3
    } hum_state_e;

    // Largest legal humidity reading in percent RH.
    localparam int HUM_MAX = 100;

    // Returns {dehumidifier_en, humidifier_en}. A single state can only
    // ever produce one of the two, so the enables cannot overlap.
    function automatic logic [1:0] state_to_en(hum_state_e s);
        return {s == ST_DEHUMIDIFY, s == ST_HUMIDIFY};
    endfunction

endpackage

// File: rtl/hum_persist.sv
// rtl/hum_persist.sv - saturating consecutive-sample counter with inc/clear/hold and hit
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        force the count to 0 (wins over sample)
//   sample     an accepted sample is present this cycle
//   match      the accepted sample qualifies (increment) or not (clear)
//   hit        this sample brings the count to PERSIST
module hum_persist #(
    parameter int PERSIST = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic sample,
    input  logic match,
    output logic hit
);

    localparam int CW = $clog2(PERSIST + 1);
    localparam logic [CW-1:0] SAT = CW'(PERSIST);

    logic [CW-1:0] cnt;

    // Combinational from the registered count so the FSM can act on the
    // same edge that the count would reach PERSIST.
    assign hit = sample && match && (cnt >= SAT - CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (sample) begin
            if (!match)
                cnt <= '0;
            else if (cnt != SAT)
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hum_ctrl.sv
// rtl/hum_ctrl.sv - humidity regulation FSM with hysteresis, persistence, min on-time and cooldown
//
// Ports:
//   pclk, preset             clock and synchronous active-high reset
//   ctrl_en                  controller enable; low forces IDLE and clears the fault
//   hum_valid, hum_data      one-cycle sample strobe and sample (0..100 legal)
//   hum_low_th, hum_high_th  dry / wet thresholds
//   hyst                     release hysteresis
//   humidifier_en            registered, high in HUMIDIFY
//   dehumidifier_en          registered, high in DEHUMIDIFY
//   hum_fault                sticky out-of-range sample flag
//   state_o                  current state encoding
module hum_ctrl
    import hum_ctrl_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int PERSIST         = 3,
    parameter int MIN_ON_CYCLES   = 100_000_000,
    parameter int COOLDOWN_CYCLES = 200_000_000
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              ctrl_en,
    input  logic              hum_valid,
    input  logic [DATA_W-1:0] hum_data,
    input  logic [DATA_W-1:0] hum_low_th,
    input  logic [DATA_W-1:0] hum_high_th,
    input  logic [DATA_W-1:0] hyst,
    output logic              humidifier_en,
    output logic              dehumidifier_en,
    output logic              hum_fault,
    output logic [1:0]        state_o
);

    localparam int MAX_CYC = (MIN_ON_CYCLES > COOLDOWN_CYCLES) ? MIN_ON_CYCLES : COOLDOWN_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    hum_state_e    state, state_nxt;
    logic          fault_nxt;
    logic [TW-1:0] timer;

    logic accepted, fault_sample, cfg_ok, dwell_done;
    logic dry_hit, wet_hit, go_dry, go_wet, cnt_clr;

    logic        [DATA_W:0]   hum_sum;
    logic        [DATA_W:0]   hum_rel;
    logic signed [DATA_W:0]   dehum_diff;
    logic        [DATA_W-1:0] dehum_rel;

    // Samples are ignored entirely while a fault is latched.
    assign accepted     = hum_valid && !hum_fault;
    assign fault_sample = accepted && (hum_data > DATA_W'(HUM_MAX));
    assign cfg_ok       = hum_low_th < hum_high_th;
    assign dwell_done   = timer >= TW'(MIN_ON_CYCLES);

    // Release points, widened by one bit so the sum/difference cannot wrap.
    assign hum_sum    = {1'b0, hum_low_th} + {1'b0, hyst};
    assign hum_rel    = (hum_sum > (DATA_W+1)'(HUM_MAX)) ? (DATA_W+1)'(HUM_MAX) : hum_sum;
    assign dehum_diff = $signed({1'b0, hum_high_th}) - $signed({1'b0, hyst});
    assign dehum_rel  = dehum_diff[DATA_W] ? '0 : dehum_diff[DATA_W-1:0];

    assign go_dry = (state == ST_IDLE) && ctrl_en && cfg_ok && !fault_sample && dry_hit;
    assign go_wet = (state == ST_IDLE) && ctrl_en && cfg_ok && !fault_sample && wet_hit;

    // Counters only run in IDLE with a valid configuration; they are also
    // zeroed on the edge that leaves IDLE so a new mode starts from scratch.
    assign cnt_clr = !ctrl_en || (state != ST_IDLE) || !cfg_ok || fault_sample || go_dry || go_wet;

    hum_persist #(.PERSIST(PERSIST)) u_dry (
        .clk    (pclk),
        .rst    (preset),
        .clr    (cnt_clr),
        .sample (accepted),
        .match  (hum_data < hum_low_th),
        .hit    (dry_hit)
    );

    hum_persist #(.PERSIST(PERSIST)) u_wet (
        .clk    (pclk),
        .rst    (preset),
        .clr    (cnt_clr),
        .sample (accepted),
        .match  (hum_data > hum_high_th),
        .hit    (wet_hit)
    );

    always_comb begin
        state_nxt = state;
        fault_nxt = hum_fault;
        if (!ctrl_en) begin
            state_nxt = ST_IDLE;
            fault_nxt = 1'b0;
        end else if (fault_sample) begin
            state_nxt = ST_IDLE;
            fault_nxt = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go_dry)
                        state_nxt = ST_HUMIDIFY;
                    else if (go_wet)
                        state_nxt = ST_DEHUMIDIFY;
                end
                ST_HUMIDIFY: begin
                    if (accepted && dwell_done && ({1'b0, hum_data} >= hum_rel))
                        state_nxt = ST_COOLDOWN;
                end
                ST_DEHUMIDIFY: begin
                    if (accepted && dwell_done && (hum_data <= dehum_rel))
                        state_nxt = ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    if (timer == TW'(COOLDOWN_CYCLES - 1))
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state           <= ST_IDLE;
            timer           <= '0;
            hum_fault       <= 1'b0;
            humidifier_en   <= 1'b0;
            dehumidifier_en <= 1'b0;
        end else begin
            state                            <= state_nxt;
            hum_fault                        <= fault_nxt;
            {dehumidifier_en, humidifier_en} <= state_to_en(state_nxt);
            // One timer serves both dwell and cooldown: restart on any
            // state change, idle at 0, otherwise count up and saturate.
            if (state_nxt != state || state_nxt == ST_IDLE)
                timer <= '0;
            else if (timer != {TW{1'b1}})
                timer <= timer + TW'(1);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_hum_ctrl.sv
// tb/tb_hum_ctrl.sv - self-checking bench for hum_ctrl against a behavioural reference model
module tb_hum_ctrl;

    localparam int P    = 3;
    localparam int MON  = 8;
    localparam int COOL = 4;

    logic       pclk;
    logic       rst, en, vld;
    logic [7:0] dat, low, high, hy;
    logic       hum_en, dehum_en, fault;
    logic [1:0] st;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_mode;
    bit m_fault;
    int cyc;
    int entry;
    int hist[$];

    hum_ctrl #(
        .DATA_W          (8),
        .PERSIST         (P),
        .MIN_ON_CYCLES   (MON),
        .COOLDOWN_CYCLES (COOL)
    ) dut (
        .pclk            (pclk),
        .preset          (rst),
        .ctrl_en         (en),
        .hum_valid       (vld),
        .hum_data        (dat),
        .hum_low_th      (low),
        .hum_high_th     (high),
        .hyst            (hy),
        .humidifier_en   (hum_en),
        .dehumidifier_en (dehum_en),
        .hum_fault       (fault),
        .state_o         (st)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model of the rules: mode 0 idle, 1 humidify, 2 dehumidify, 3 cooldown.
    // hist holds classifications of recent accepted samples seen in idle.
    task automatic model_step();
        int spent, cls, lo, hi, h, d, thr;
        bit acc, same;
        lo = int'(low); hi = int'(high); h = int'(hy); d = int'(dat);
        cyc++;
        if (rst || !en) begin
            m_mode = 0; m_fault = 0; hist.delete(); entry = cyc;
        end else if (vld && !m_fault && d > 100) begin
            m_mode = 0; m_fault = 1; hist.delete(); entry = cyc;
        end else begin
            acc   = vld && !m_fault;
            spent = cyc - entry;
            case (m_mode)
                0: begin
                    if (lo >= hi) begin
                        hist.delete();
                    end else if (acc) begin
                        cls = (d < lo) ? 1 : ((d > hi) ? 2 : 0);
                        hist.push_back(cls);
                        if (hist.size() > P) void'(hist.pop_front());
                        same = (hist.size() == P) && (cls != 0);
                        foreach (hist[k]) if (hist[k] != cls) same = 0;
                        if (same) begin
                            m_mode = cls; entry = cyc; hist.delete();
                        end
                    end
                end
                1: begin
                    thr = (lo + h > 100) ? 100 : lo + h;
                    if (acc && spent - 1 >= MON && d >= thr) begin
                        m_mode = 3; entry = cyc;
                    end
                end
                2: begin
                    thr = (hi - h < 0) ? 0 : hi - h;
                    if (acc && spent - 1 >= MON && d <= thr) begin
                        m_mode = 3; entry = cyc;
                    end
                end
                default: begin
                    if (spent >= COOL) begin
                        m_mode = 0; entry = cyc;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge pclk);
        model_step();
        #1;
        chk("hum_en",   32'(hum_en),   32'(m_mode == 1));
        chk("dehum_en", 32'(dehum_en), 32'(m_mode == 2));
        chk("fault",    32'(fault),    32'(m_fault));
        chk("state",    32'(st),       32'(m_mode));
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        repeat (n) step();
    endtask

    task automatic smp(input int d);
        vld = 1'b1;
        dat = 8'(d);
        step();
        vld = 1'b0;
    endtask

    initial begin
        int regime, r;
        cyc = 0; entry = 0; m_mode = 0; m_fault = 0;
        rst = 1'b1; en = 1'b1; vld = 1'b0; dat = '0;
        low = 8'd40; high = 8'd60; hy = 8'd5;

        // Reset
        step();
        chk("rst_state", 32'(st), 0);
        chk("rst_hum", 32'(hum_en), 0);
        chk("rst_dehum", 32'(dehum_en), 0);
        chk("rst_fault", 32'(fault), 0);
        rst = 1'b0;
        idle(2);

        // Dry persistence and humidify release
        smp(35); smp(35); smp(35);
        chk("dry_enter", 32'(hum_en), 1);
        idle(2); smp(46);
        chk("hum_early", 32'(hum_en), 1);
        idle(8); smp(44);
        chk("hum_hold44", 32'(hum_en), 1);
        smp(46);
        chk("hum_rel46", 32'(hum_en), 0);
        chk("cool_enter", 32'(st), 3);
        idle(3);
        chk("cool_3", 32'(st), 3);
        idle(1);
        chk("cool_done", 32'(st), 0);

        // Broken dry run
        smp(35); smp(35); smp(50); smp(35);
        chk("dry_broken", 32'(hum_en), 0);
        smp(50); idle(1);

        // Dehumidify release
        smp(70); smp(70); smp(70);
        chk("wet_enter", 32'(dehum_en), 1);
        idle(10); smp(56);
        chk("dehum_hold56", 32'(dehum_en), 1);
        smp(55);
        chk("dehum_rel55", 32'(st), 3);
        idle(4);

        // Fault handling
        smp(35); smp(35); smp(35);
        idle(1); smp(101);
        chk("fault_hum", 32'(hum_en), 0);
        chk("fault_set", 32'(fault), 1);
        chk("fault_idle", 32'(st), 0);
        smp(35); smp(35); smp(35);
        chk("fault_ignore", 32'(st), 0);
        en = 1'b0; step(); en = 1'b1;
        chk("fault_clr", 32'(fault), 0);
        en = 1'b0; smp(101); en = 1'b1;
        chk("en_over_fault", 32'(fault), 0);
        idle(1);

        // Saturated humidify release point
        low = 8'd98; high = 8'd99; hy = 8'd10;
        smp(35); smp(35); smp(35);
        idle(10); smp(99);
        chk("sat_hold99", 32'(hum_en), 1);
        smp(100);
        chk("sat_rel100", 32'(st), 3);
        idle(4);

        // Floored dehumidify release point
        low = 8'd2; high = 8'd5; hy = 8'd10;
        smp(70); smp(70); smp(70);
        idle(10); smp(1);
        chk("floor_hold1", 32'(dehum_en), 1);
        smp(0);
        chk("floor_rel0", 32'(st), 3);
        idle(4);

        // Invalid configuration
        low = 8'd60; high = 8'd40; hy = 8'd5;
        smp(35); smp(35); smp(35); smp(70); smp(70); smp(70);
        chk("bad_cfg", 32'(st), 0);

        // Reset mid-mode
        low = 8'd40; high = 8'd60;
        smp(35); smp(35); smp(35); idle(2);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid", 32'(hum_en), 0);

        // Randomized traffic
        regime = 35;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                low  = 8'($urandom_range(0, 100));
                high = 8'($urandom_range(0, 100));
                hy   = 8'($urandom_range(0, 30));
            end
            if ($urandom_range(0, 39) == 0) regime = int'($urandom_range(0, 100));
            rst = ($urandom_range(0, 999) == 0);
            en  = ($urandom_range(0, 149) != 0);
            vld = ($urandom_range(0, 2) == 0);
            r   = int'($urandom_range(0, 99));
            if (r < 2)       dat = 8'($urandom_range(101, 255));
            else if (r < 70) dat = 8'(regime);
            else             dat = 8'($urandom_range(0, 100));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
